// File: rtl/sti_word_feeder.sv
// sti_word_feeder: upstream stage of the STI serializer.
// Buffers parallel-in word commands in a small FIFO and issues them to the STI
// one at a time. Each issue is a one-cycle load strobe with pi_* held until the
// serial burst has finished. After the word flagged last, pi_end pulses once and
// done latches. Burst lengths are checked against pi_length (err_len), and a
// missing burst start is flagged as a timeout (err_to).
module sti_word_feeder #(
  parameter int DEPTH    = 4,   // FIFO entries, power of 2, >= 2
  parameter int GAP      = 1,   // idle cycles after a burst before the next issue
  parameter int START_TO = 15   // max cycles from load to so_valid rising
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_length,
  input  logic        in_fill,
  input  logic        in_msb,
  input  logic        in_low,
  input  logic        in_last,
  input  logic        so_valid,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  output logic        done,
  output logic        err_len,
  output logic        err_to
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = 22;

  // Last cycle index of the gap wait; GAP=0 still spends one cycle in GAPW.
  localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
  localparam logic [7:0] TO_LAST  = 8'(START_TO - 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WSTART,
    S_WBUSY,
    S_GAPW,
    S_END,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr_reg, rd_ptr_reg;
  logic               fifo_empty, fifo_full;
  logic [ENTRY_W-1:0] head;
  logic               push, pop;
  logic               last_accepted_reg;

  // Issued word, held for the whole burst
  logic [15:0] pi_data_reg;
  logic [1:0]  pi_length_reg;
  logic        pi_fill_reg, pi_msb_reg, pi_low_reg;
  logic        cur_last_reg;
  logic        load_reg;

  // Burst supervision
  logic [7:0]  to_cnt_reg;
  logic [7:0]  bit_cnt_reg;
  logic [3:0]  gap_cnt_reg;
  logic [7:0]  exp_bits;
  logic        gap_done;
  logic        set_err_len, set_err_to;
  logic        err_len_reg, err_to_reg;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head       = mem[rd_ptr_reg[AW-1:0]];

  // No accepts once the stream's last word is in, and none while in reset.
  assign in_ready = !reset && !fifo_full && !last_accepted_reg && (state_reg != S_DONE);
  assign push     = in_valid && in_ready;

  assign exp_bits = {2'b00, ({1'b0, pi_length_reg} + 3'd1), 3'b000};
  assign gap_done = (gap_cnt_reg == GAP_LAST);

  assign load      = load_reg;
  assign pi_data   = pi_data_reg;
  assign pi_length = pi_length_reg;
  assign pi_fill   = pi_fill_reg;
  assign pi_msb    = pi_msb_reg;
  assign pi_low    = pi_low_reg;
  assign pi_end    = (state_reg == S_END);
  assign done      = (state_reg == S_DONE);
  assign err_len   = err_len_reg;
  assign err_to    = err_to_reg;

  // FIFO write port: plain array so it can map onto distributed/block RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {in_last, in_low, in_msb, in_fill, in_length, in_data};
    end
  end

  // FIFO pointers and the "last word accepted" latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      last_accepted_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (in_last) begin
          last_accepted_reg <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state, pop request and error-set decisions
  always_comb begin
    state_next  = state_reg;
    pop         = 1'b0;
    set_err_len = 1'b0;
    set_err_to  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_WSTART;
        end
      end
      S_WSTART: begin
        if (so_valid) begin
          state_next = S_WBUSY;
        end else if (to_cnt_reg == TO_LAST) begin
          set_err_to = 1'b1;
          state_next = S_GAPW;
        end
      end
      S_WBUSY: begin
        if (!so_valid) begin
          set_err_len = (bit_cnt_reg != exp_bits);
          state_next  = S_GAPW;
        end
      end
      S_GAPW: begin
        if (gap_done) begin
          state_next = cur_last_reg ? S_END : S_IDLE;
        end
      end
      S_END: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_DONE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Issue registers, burst counters and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_reg      <= 1'b0;
      pi_data_reg   <= '0;
      pi_length_reg <= '0;
      pi_fill_reg   <= 1'b0;
      pi_msb_reg    <= 1'b0;
      pi_low_reg    <= 1'b0;
      cur_last_reg  <= 1'b0;
      to_cnt_reg    <= '0;
      bit_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      err_len_reg   <= 1'b0;
      err_to_reg    <= 1'b0;
    end else begin
      load_reg <= pop;
      if (pop) begin
        {cur_last_reg, pi_low_reg, pi_msb_reg, pi_fill_reg, pi_length_reg, pi_data_reg} <= head;
        to_cnt_reg <= '0;
      end
      if (state_reg == S_WSTART) begin
        if (so_valid) begin
          bit_cnt_reg <= 8'd1;
        end else begin
          to_cnt_reg <= to_cnt_reg + 8'd1;
        end
      end
      // Saturate so an absurdly long burst can never wrap back to a legal count
      if (state_reg == S_WBUSY && so_valid && bit_cnt_reg != 8'hFF) begin
        bit_cnt_reg <= bit_cnt_reg + 8'd1;
      end
      gap_cnt_reg <= (state_reg == S_GAPW) ? gap_cnt_reg + 4'd1 : 4'd0;
      err_len_reg <= err_len_reg | set_err_len;
      err_to_reg  <= err_to_reg | set_err_to;
    end
  end

endmodule

// File: tb/tb_sti_word_feeder.sv
// Bench for sti_word_feeder: directed stream scenarios with randomized word
// contents and STI response delays, checked against a word-order scoreboard and
// timing/flag expectations derived from the feeder's issue rules.
module tb_sti_word_feeder;

  localparam int DEPTH    = 4;
  localparam int GAP      = 1;
  localparam int START_TO = 15;
  localparam int GAPC     = (GAP == 0) ? 1 : GAP;   // cycles spent waiting after a burst

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  len;
    logic        fill;
    logic        msb;
    logic        low;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_length = '0;
  logic        in_fill = 1'b0, in_msb = 1'b0, in_low = 1'b0, in_last = 1'b0;
  logic        so_valid = 1'b0;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill, pi_msb, pi_low, pi_end, done, err_len, err_to;

  sti_word_feeder #(.DEPTH(DEPTH), .GAP(GAP), .START_TO(START_TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_length(in_length), .in_fill(in_fill),
    .in_msb(in_msb), .in_low(in_low), .in_last(in_last),
    .so_valid(so_valid), .load(load),
    .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
    .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .done(done), .err_len(err_len), .err_to(err_to)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state
  word_t exp_q[$];          // words expected to be issued, in order
  int    plan_q[$];         // STI burst length per issued word (0 = never starts)
  logic  exp_err_len = 1'b0;
  logic  exp_err_to  = 1'b0;
  logic [20:0] exp_hold = '0;
  int    sti_delay = 0;     // 0 = random 1..3 cycles, else fixed

  int checks = 0, errors = 0;
  int load_cnt = 0, last_load_cyc = -1, end_cnt = 0, last_end_cyc = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] pack_w(input word_t w);
    return {w.data, w.len, w.fill, w.msb, w.low};
  endfunction

  function automatic word_t rand_word(input logic [1:0] len, input logic last);
    word_t w;
    w.data = 16'($urandom);
    w.len  = len;
    w.fill = 1'($urandom);
    w.msb  = 1'($urandom);
    w.low  = 1'($urandom);
    w.last = last;
    return w;
  endfunction

  // Monitor: issued words in order, pi_* held between loads, pi_end pulses
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_hold = '0;
      end else begin
        if (load === 1'b1) begin
          load_cnt++;
          last_load_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("load_unexpected", 32'(load), 0);
          end else begin
            exp_hold = pack_w(exp_q.pop_front());
            check("load_word", 32'({pi_data, pi_length, pi_fill, pi_msb, pi_low}), 32'(exp_hold));
          end
        end else begin
          check("pi_hold", 32'({pi_data, pi_length, pi_fill, pi_msb, pi_low}), 32'(exp_hold));
        end
        if (pi_end === 1'b1) begin
          end_cnt++;
          last_end_cyc = cyc;
        end
      end
    end
  end

  // STI model: after each load, wait a delay then hold so_valid for the planned length
  initial begin
    int n, d;
    logic abort;
    forever begin
      @(negedge clk);
      if (!reset && load === 1'b1) begin
        n = (plan_q.size() > 0) ? plan_q.pop_front() : 0;
        if (n > 0) begin
          d = (sti_delay > 0) ? sti_delay : int'($urandom_range(1, 3));
          abort = 1'b0;
          for (int i = 0; i < d && !abort; i++) begin
            @(negedge clk);
            if (reset) abort = 1'b1;
          end
          if (!abort) begin
            so_valid = 1'b1;
            for (int i = 0; i < n && !abort; i++) begin
              @(negedge clk);
              if (reset) abort = 1'b1;
            end
            so_valid = 1'b0;
          end
        end
      end
    end
  end

  // Offer a word from a negedge; waits (bounded) for acceptance, returns at a negedge
  task automatic push(input word_t w, input int plan, input int max_wait, output logic first_ready);
    int waited;
    in_data = w.data; in_length = w.len; in_fill = w.fill;
    in_msb = w.msb; in_low = w.low; in_last = w.last;
    in_valid = 1'b1;
    first_ready = in_ready;
    waited = 0;
    while (in_ready !== 1'b1 && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready === 1'b1) begin
      exp_q.push_back(w);
      plan_q.push_back(plan);
      if (plan == 0) exp_err_to = 1'b1;
      else if (plan != 8 * (int'(w.len) + 1)) exp_err_len = 1'b1;
      @(negedge clk);
    end else begin
      check("push_timeout", 32'(in_ready), 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_loads(input int target, input int limit);
    int k = 0;
    while (load_cnt < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (load_cnt < target) check("load_timeout", 32'(load_cnt), 32'(target));
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("done_reached", 32'(done), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({load, pi_end, done, err_len, err_to, in_ready}), 0);
    check({tag, "_pi"}, 32'({pi_data, pi_length, pi_fill, pi_msb, pi_low}), 0);
  endtask

  // Called at a negedge; asserts reset off-edge, checks outputs clear at once
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_zero(tag);
    repeat (2) @(negedge clk);
    exp_q.delete();
    plan_q.delete();
    exp_err_len = 1'b0;
    exp_err_to  = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check({tag, "_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    word_t w;
    logic  rdy;
    int    c0, base, lc, ec;

    // Reset state
    @(negedge clk);
    check_zero("reset_init");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 1);

    // 1: single last word, 16-bit burst
    sti_delay = 1;
    w = '{data: 16'hA5C3, len: 2'd1, fill: 1'b0, msb: 1'b1, low: 1'b0, last: 1'b1};
    c0 = cyc;
    base = load_cnt;
    ec = end_cnt;
    push(w, 16, 5, rdy);
    check("t1_ready", 32'(rdy), 1);
    check("t1_ready_after_last", 32'(in_ready), 0);
    wait_loads(base + 1, 10);
    lc = last_load_cyc;
    check("t1_load_latency", 32'(lc), 32'(c0 + 2));
    wait_done(100);
    check("t1_end_count", 32'(end_cnt), 32'(ec + 1));
    check("t1_end_cycle", 32'(last_end_cyc), 32'(lc + 1 + 16 + 1 + GAPC));
    check("t1_done_cycle", 32'(cyc), 32'(last_end_cyc + 1));
    check("t1_pi_data", 32'(pi_data), 32'h0000A5C3);
    check("t1_err_len", 32'(err_len), 32'(exp_err_len));
    check("t1_err_to", 32'(err_to), 32'(exp_err_to));

    // 6: words offered after the last one are refused
    base = load_cnt;
    w = rand_word(2'($urandom), 1'b0);
    in_data = w.data; in_length = w.len; in_last = 1'b0;
    in_valid = 1'b1;
    check("t6_ready", 32'(in_ready), 0);
    repeat (20) @(negedge clk);
    in_valid = 1'b0;
    check("t6_no_load", 32'(load_cnt), 32'(base));
    check("t6_done_sticky", 32'(done), 1);
    check("t6_end_once", 32'(end_cnt), 32'(ec + 1));

    // 2: fill the FIFO behind a long burst, all lengths correct
    do_reset("t2_reset");
    sti_delay = 0;
    base = load_cnt;
    push(rand_word(2'd3, 1'b0), 32, 5, rdy);
    check("t2_ready_0", 32'(rdy), 1);
    for (int k = 1; k <= DEPTH; k++) begin
      w = rand_word(2'(k - 1), 1'b0);
      push(w, 8 * k, 5, rdy);
      check("t2_ready_fill", 32'(rdy), 1);
    end
    w = rand_word(2'($urandom), 1'b1);
    push(w, 8 * (int'(w.len) + 1), 300, rdy);
    check("t2_full_stall", 32'(rdy), 0);
    wait_done(1000);
    check("t2_loads", 32'(load_cnt), 32'(base + DEPTH + 2));
    check("t2_err_len", 32'(err_len), 32'(exp_err_len));
    check("t2_err_to", 32'(err_to), 32'(exp_err_to));

    // 3: 24-bit word with a 20-cycle burst sets sticky err_len, stream continues
    do_reset("t3_reset");
    base = load_cnt;
    push(rand_word(2'd2, 1'b0), 20, 5, rdy);
    w = rand_word(2'($urandom), 1'b1);
    push(w, 8 * (int'(w.len) + 1), 100, rdy);
    wait_done(300);
    check("t3_loads", 32'(load_cnt), 32'(base + 2));
    check("t3_err_len", 32'(err_len), 32'(exp_err_len));
    check("t3_err_to", 32'(err_to), 32'(exp_err_to));

    // 4: STI never starts -> timeout after START_TO cycles, next word after the gap
    do_reset("t4_reset");
    sti_delay = 1;
    base = load_cnt;
    push(rand_word(2'($urandom), 1'b0), 0, 5, rdy);
    w = rand_word(2'($urandom), 1'b1);
    push(w, 8 * (int'(w.len) + 1), 100, rdy);
    wait_loads(base + 1, 10);
    lc = last_load_cyc;
    while (cyc < lc + START_TO - 1) @(negedge clk);
    check("t4_err_to_before", 32'(err_to), 0);
    @(negedge clk);
    check("t4_err_to_at", 32'(err_to), 1);
    wait_loads(base + 2, 20);
    check("t4_next_load", 32'(last_load_cyc), 32'(lc + START_TO + GAPC + 1));
    wait_done(200);
    check("t4_err_len", 32'(err_len), 32'(exp_err_len));
    check("t4_err_to", 32'(err_to), 32'(exp_err_to));

    // 5: reset in the middle of a burst, then a fresh stream
    do_reset("t5_pre_reset");
    sti_delay = 0;
    base = load_cnt;
    push(rand_word(2'd3, 1'b0), 32, 5, rdy);
    push(rand_word(2'($urandom), 1'b1), 8, 5, rdy);
    wait_loads(base + 1, 10);
    repeat (10) @(negedge clk);
    check("t5_busy", 32'({load_cnt, done}), 32'({base + 1, 1'b0}));
    do_reset("t5_mid_reset");
    repeat (5) @(negedge clk);
    check("t5_abandoned", 32'(load_cnt), 32'(base + 1));
    for (int k = 0; k < 3; k++) begin
      w = rand_word(2'($urandom), 1'(k == 2));
      push(w, 8 * (int'(w.len) + 1), 100, rdy);
    end
    wait_done(500);
    check("t5_loads", 32'(load_cnt), 32'(base + 4));
    check("t5_errs", 32'({err_len, err_to}), 32'({exp_err_len, exp_err_to}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
    $fatal(1, "global timeout");
  end

endmodule
